// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the fetch/decode slice: data width, major
// opcodes, the bubble encoding, decode-field widths and the IF/ID update ops.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  // Major opcodes (inst[6:0]) the Controller decodes.
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  // All-zero word: decodes as the Controller's empty instruction.
  localparam logic [XLEN-1:0] BUBBLE_INST = 32'h0000_0000;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned FUNCT7_W = 1;

  // What the IF/ID register does on the next clock edge.
  typedef enum logic [1:0] {
    IFID_LOAD   = 2'd0,
    IFID_HOLD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_op_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register holding {pc, inst, valid}. Loads, holds, or takes
// a bubble (inst cleared, valid cleared, pc kept) under control of the top.
module if_id_reg
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  ifid_op_e        op,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_inst,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_inst,
  output logic            id_valid
);

  logic [XLEN-1:0] pc_d, pc_q;
  logic [XLEN-1:0] inst_d, inst_q;
  logic            valid_d, valid_q;

  // Next-state select for the register contents.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    unique case (op)
      IFID_LOAD: begin
        pc_d    = load_pc;
        inst_d  = load_inst;
        valid_d = 1'b1;
      end
      IFID_BUBBLE: begin
        inst_d  = BUBBLE_INST;
        valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Register update with synchronous reset to an empty slot.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (rst) begin
      pc_q    <= '0;
      inst_q  <= BUBBLE_INST;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign id_pc    = pc_q;
  assign id_inst  = inst_q;
  assign id_valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: owns the PC, addresses a 1-cycle synchronous imem, and
// feeds the IF/ID register with stall, redirect-with-flush and sticky halt.
// Optional feature macro: IF_FETCH_CNT_EN adds the fetch_cnt port/counter.
module fetch_stage
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              halt,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_inst,
  output logic              id_valid,
  output logic [6:0]        opcode,
  output logic [2:0]        funct3,
  output logic              funct7
`ifdef IF_FETCH_CNT_EN
  ,output logic [31:0]      fetch_cnt
`endif
);

  logic [XLEN-1:0] pc_d, pc_q;
  logic            halted_d, halted_q;
  logic [XLEN-1:0] nxt_pc;
  logic            stop;
  ifid_op_e        ifid_op;

  assign stop = halted_q | halt;

  // Next-PC and IF/ID operation, both following the same priority chain.
  always_comb begin
    nxt_pc  = pc_q + 32'd4;
    ifid_op = IFID_LOAD;
    if (rst) begin
      nxt_pc  = RESET_PC;
      ifid_op = IFID_BUBBLE;
    end else if (stop) begin
      nxt_pc  = pc_q;
      ifid_op = IFID_BUBBLE;
    end else if (redirect) begin
      // The word in flight belongs to the wrong path, so it is dropped.
      nxt_pc  = {redirect_pc[31:2], 2'b00};
      ifid_op = IFID_BUBBLE;
    end else if (stall) begin
      nxt_pc  = pc_q;
      ifid_op = IFID_HOLD;
    end
  end

  assign pc_d      = nxt_pc;
  assign halted_d  = stop;
  assign imem_addr = nxt_pc[ADDR_W+1:2];

  // PC and sticky-halt registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  // pc_q is the address whose data is on imem_rdata this cycle.
  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .op       (ifid_op),
    .load_pc  (pc_q),
    .load_inst(imem_rdata),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_valid (id_valid)
  );

  assign opcode = id_inst[OPCODE_W-1:0];
  assign funct3 = id_inst[12+FUNCT3_W-1:12];
  assign funct7 = id_inst[30];

  // Address bits outside the imem word index are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{redirect_pc[1:0], nxt_pc[31:ADDR_W+2], nxt_pc[1:0]};

`ifdef IF_FETCH_CNT_EN
  logic [31:0] cnt_d, cnt_q;

  // Count cycles in which IF/ID captures a real instruction.
  always_comb begin
    cnt_d = cnt_q;
    if (ifid_op == IFID_LOAD) cnt_d = cnt_q + 32'd1;
  end

  // Fetch counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign fetch_cnt = cnt_q;
`endif

endmodule
